serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
//  Uses a single 1-bit full-subtractor cell and a borrow flip-flop.
//  Trades WIDTH cycles of latency for one arithmetic cell.
//  Paired with the parallel adder datapath for the add/subtract unit; a start/busy/done handshake sequences it.
// PARAMETERS
//  WIDTH  6  operand/result width in bits (>=2)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      request; sampled on rising edge, accepted only when busy=0
//  a         in   WIDTH  minuend, captured on accepted start
//  b         in   WIDTH  subtrahend, captured on accepted start
//  bin       in   1      borrow-in, captured on accepted start
//  busy      out  1      high while bits are being processed
//  done      out  1      one-cycle pulse: diff/bout valid
//  diff      out  WIDTH  result, held from done until next accepted start
//  bout      out  1      borrow-out (1 => A < B+BIN unsigned)
//  diff_bit  out  1      serial result bit, LSB first
//  bit_vld   out  1      qualifies diff_bit
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State is IDLE.
//   - busy, done, diff, bout, diff_bit and bit_vld are all 0.
//   - Shift registers, borrow FF and bit counter are cleared.
//  FSM states: IDLE, SHIFT, DONE.
//   - IDLE/DONE + start=1 -> SHIFT.
//     Load a_sr<=a, b_sr<=b, brw<=bin, cnt<=0, and clear diff.
//   - SHIFT, each edge -> process one bit:
//     d = a_sr[0]^b_sr[0]^brw;  bo = (~a_sr[0]&b_sr[0]) | (~a_sr[0]&brw) | (b_sr[0]&brw).
//     diff <= {d, diff[WIDTH-1:1]}; a_sr, b_sr shift right; brw<=bo; cnt<=cnt+1.
//   - SHIFT with cnt==WIDTH-1 -> DONE. bout<=bo on that edge.
//   - DONE -> IDLE on the next edge when start=0.
//  Handshake and timing
//   - busy = (state==SHIFT).
//   - done = (state==DONE), so it is exactly one cycle wide.
//   - Accepted start on edge T0 puts busy high in cycles T0..T(WIDTH-1).
//   - done is high in the cycle after edge T(WIDTH); latency is WIDTH+1 edges from start to done.
//   - start while busy=1 is ignored; operands are not re-captured.
//   - start in DONE is accepted, giving back-to-back operations with no IDLE gap.
//   - diff_bit/bit_vld are registered. bit i appears in the cycle after its processing edge.
//     bit_vld is high for WIDTH consecutive cycles, ending in the done cycle.
//  Arithmetic
//   - Unsigned modulo 2^WIDTH.
//   - {bout,diff} equals (A - B - BIN) in WIDTH+1-bit two's complement (bout = sign/borrow).
//  Boundaries
//   - cnt width is $clog2(WIDTH). cnt never wraps past WIDTH-1 because the FSM leaves SHIFT.
//   - rst_n low mid-operation aborts immediately. All outputs go to 0 and no done is issued.
//   - a, b and bin changing during SHIFT have no effect.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a default-width constant (6).
//  - One sub-module, full_sub_cell: 1-bit combinational full subtractor (a, b, bin -> d, bout).
//  - Top level holds the FSM, the shift registers, the counter and the borrow FF.
// TESTING
//  1. a=25, b=10, bin=0, start pulse -> done after WIDTH+1 edges; diff=15, bout=0.
//     diff_bit sequence (LSB first) 1,1,1,1,0,0.
//  2. a=10, b=25, bin=0 -> diff=49 (6'h31), bout=1.
//  3. a=0, b=0, bin=1 -> diff=63, bout=1. Separately: a=63, b=63, bin=0 -> diff=0, bout=0.
//  4. start held high across a whole op with a/b changed mid-SHIFT.
//     -> first result uses the original operands.
//     -> second op starts from DONE with no IDLE cycle, using the operands present at the DONE edge.
//  5. rst_n asserted at bit 3 of 7-2 -> all outputs 0 immediately, no done pulse.
//     After release, 7-2 -> diff=5, bout=0.
//  6. Random sweep of 1000 vectors against the reference model {bout,diff} = A-B-BIN.
//     Check done is one cycle wide and busy=0 whenever done=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  // Default operand/result width in bits.
  localparam int unsigned DEFAULT_WIDTH = 6;

  // Sequencer states. IDLE waits for a request, SHIFT processes one bit per
  // clock, DONE presents the finished result for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_sub_cell.sv
// 1-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Difference bit and borrow: borrow whenever b+bin exceeds a for this bit.
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);
  end

endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell plus a
// borrow flip-flop. Sequenced by a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             diff_bit,
  output logic             bit_vld
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             dbit_q, dbit_d;
  logic             bvld_q, bvld_d;

  logic             accept;
  logic             cell_d;
  logic             cell_bo;

  // Single arithmetic cell working on the current LSBs and the stored borrow.
  full_sub_cell u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (brw_q),
    .d_o    (cell_d),
    .bout_o (cell_bo)
  );

  // A request is taken whenever no bits are in flight (IDLE or DONE).
  always_comb begin
    accept = start && (state_q != SHIFT);
  end

  // Next-state and datapath update; serial-bit outputs default to idle.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    dbit_d  = 1'b0;
    bvld_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        brw_d  = cell_bo;
        cnt_d  = cnt_q + 1'b1;
        dbit_d = cell_d;
        bvld_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bout_d  = cell_bo;
          cnt_d   = cnt_q;
        end
      end
      DONE: begin
        state_d = accept ? SHIFT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand capture shared by the IDLE and DONE entries into SHIFT.
    if (accept) begin
      a_sr_d = a;
      b_sr_d = b;
      brw_d  = bin;
      cnt_d  = '0;
      diff_d = '0;
    end
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      dbit_q  <= 1'b0;
      bvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      dbit_q  <= dbit_d;
      bvld_q  <= bvld_d;
    end
  end

  // Handshake and result outputs.
  always_comb begin
    busy     = (state_q == SHIFT);
    done     = (state_q == DONE);
    diff     = diff_q;
    bout     = bout_q;
    diff_bit = dbit_q;
    bit_vld  = bvld_q;
  end

endmodule : serial_subtractor
